step_tick_gen: RTL and testbench

Parametrised, programmable step-pulse generator for the stepper motor controller. It is a counter-based period timer with start/stop/pause control, an optional finite step count, and double-buffered period updates that only take effect on a period boundary. Its `tick` pulse drives the motor phase sequencer. It replaces the fixed-width free-running count-to-max timer.

---
 rtl/step_tick_gen.sv | 141 ++++++++++++++
 tb/tb_step_tick_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_tick_gen.sv
// Programmable step-pulse generator: period timer with start/stop/pause,
// optional finite step count and period updates applied on period boundaries.
// Ports: clk, rst (async, active-low); start/stop/pause control;
//   period_wr/period_in load the target period (tick spacing = P+1 cycles);
//   steps_in = ticks per run (0 = continuous); ramp_start/ramp_step used only
//   when STEP_TICK_RAMP_EN is defined; outputs tick, done, busy, step_cnt,
//   cur_period.
module step_tick_gen #(
    parameter int CNT_W  = 24,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              period_wr,
    input  logic [CNT_W-1:0]  period_in,
    input  logic [STEP_W-1:0] steps_in,
    input  logic [CNT_W-1:0]  ramp_start,
    input  logic [CNT_W-1:0]  ramp_step,
    output logic              tick,
    output logic              done,
    output logic              busy,
    output logic [STEP_W-1:0] step_cnt,
    output logic [CNT_W-1:0]  cur_period
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  target, target_d;
    logic [CNT_W-1:0]  count, count_d;
    logic [CNT_W-1:0]  cur_d;
    logic [STEP_W-1:0] limit, limit_d;
    logic [STEP_W-1:0] step_d;
    logic [STEP_W-1:0] step_inc;
    logic              tick_d, done_d;

    // Target as seen this cycle: a write in the same cycle already counts.
    logic [CNT_W-1:0]  tgt_nx;
    logic [CNT_W-1:0]  start_per;
    logic [CNT_W-1:0]  wrap_per;

    assign tgt_nx   = period_wr ? period_in : target;
    assign step_inc = step_cnt + 1'b1;
    assign busy     = (state != IDLE);

`ifdef STEP_TICK_RAMP_EN
    // Ramp begins at ramp_start (never faster than target) and shrinks by
    // ramp_step per tick, saturating at target without underflow.
    assign start_per = (ramp_start < tgt_nx) ? tgt_nx : ramp_start;
    assign wrap_per  = ((cur_period > tgt_nx) &&
                        ((cur_period - tgt_nx) > ramp_step)) ?
                       (cur_period - ramp_step) : tgt_nx;
`else
    logic unused_ramp;
    assign unused_ramp = ^{ramp_start, ramp_step};
    assign start_per   = tgt_nx;
    assign wrap_per    = tgt_nx;
`endif

    always_comb begin
        state_d  = state;
        target_d = tgt_nx;
        count_d  = count;
        cur_d    = cur_period;
        limit_d  = limit;
        step_d   = step_cnt;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (period_wr) cur_d = period_in;
                if (start && !stop) begin
                    state_d = RUN;
                    count_d = '0;
                    step_d  = '0;
                    limit_d = steps_in;
                    cur_d   = start_per;
                end
            end
            RUN, PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    // Leaving PAUSE counts on the same edge, so a pause of
                    // N cycles delays the next tick by exactly N.
                    state_d = RUN;
                    // >= so a lowered period wraps on the next edge.
                    if (count >= cur_period) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        step_d  = step_inc;
                        cur_d   = wrap_per;
                        if ((limit != '0) && (step_inc == limit)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            target     <= '0;
            count      <= '0;
            cur_period <= '0;
            limit      <= '0;
            step_cnt   <= '0;
            tick       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            target     <= target_d;
            count      <= count_d;
            cur_period <= cur_d;
            limit      <= limit_d;
            step_cnt   <= step_d;
            tick       <= tick_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_step_tick_gen.sv
// Self-checking bench for step_tick_gen (default build, no ramp).
// Vector table, directed corner sequences and random stimulus vs. a model.
module tb_step_tick_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        period_wr = 1'b0;
    logic [23:0] period_in = '0;
    logic [15:0] steps_in = '0;
    logic [23:0] ramp_start = '0;
    logic [23:0] ramp_step = '0;
    logic        tick, done, busy;
    logic [15:0] step_cnt;
    logic [23:0] cur_period;

    step_tick_gen dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .period_wr(period_wr), .period_in(period_in), .steps_in(steps_in),
        .ramp_start(ramp_start), .ramp_step(ramp_step),
        .tick(tick), .done(done), .busy(busy), .step_cnt(step_cnt),
        .cur_period(cur_period)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a run is a sequence of periods of (P+1) advancing
    // cycles; only cycles without stop/pause advance.
    bit          m_act;
    int          m_el;
    logic [23:0] m_per, m_tgt;
    logic [15:0] m_lim, m_steps;
    bit          m_tick, m_done;

    typedef struct {
        logic        st;
        logic        pw;
        logic [23:0] pin;
        logic [15:0] sin;
        logic        tk;
        logic        dn;
        logic        bz;
        logic [15:0] sc;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_el = 0; m_per = '0; m_tgt = '0;
        m_lim = '0; m_steps = '0; m_tick = 0; m_done = 0;
    endtask

    task automatic model_step();
        logic [23:0] nt;
        nt = period_wr ? period_in : m_tgt;
        m_tick = 0;
        m_done = 0;
        if (!m_act) begin
            if (period_wr) m_per = period_in;
            if (start && !stop) begin
                m_act = 1; m_el = 0; m_steps = '0;
                m_lim = steps_in; m_per = nt;
            end
        end else if (stop) begin
            m_act = 0;
            m_el = 0;
        end else if (!pause) begin
            m_el++;
            if (m_el == int'(m_per) + 1) begin
                m_el = 0;
                m_tick = 1;
                m_steps = m_steps + 16'd1;
                m_per = nt;
                if (m_lim != 0 && m_steps == m_lim) begin
                    m_done = 1;
                    m_act = 0;
                end
            end
        end
        m_tgt = nt;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("tick", {31'd0, tick}, {31'd0, m_tick});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("busy", {31'd0, busy}, {31'd0, m_act});
        chk("step_cnt", {16'd0, step_cnt}, {16'd0, m_steps});
        chk("cur_period", {8'd0, cur_period}, {8'd0, m_per});
    endtask

    task automatic clr();
        start = 0; stop = 0; pause = 0; period_wr = 0;
        period_in = '0; steps_in = '0;
    endtask

    task automatic run_until_tick(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            cycle();
            if (tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic halt();
        clr();
        stop = 1;
        cycle();
        stop = 0;
        cycle();
    endtask

    task automatic apply_table();
        for (int i = 0; i < 18; i++) begin
            clr();
            start = tbl[i].st;
            period_wr = tbl[i].pw;
            period_in = tbl[i].pin;
            steps_in = tbl[i].sin;
            cycle();
            chk("tbl_tick", {31'd0, tick}, {31'd0, tbl[i].tk});
            chk("tbl_done", {31'd0, done}, {31'd0, tbl[i].dn});
            chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].bz});
            chk("tbl_step", {16'd0, step_cnt}, {16'd0, tbl[i].sc});
            chk("tbl_per", {8'd0, cur_period}, 32'd4);
        end
        clr();
    endtask

    initial begin
        int n;
        tbl[0] = '{st: 0, pw: 1, pin: 24'd4, sin: 16'd0,
                   tk: 0, dn: 0, bz: 0, sc: 16'd0};
        tbl[1] = '{st: 1, pw: 0, pin: 24'd0, sin: 16'd3,
                   tk: 0, dn: 0, bz: 1, sc: 16'd0};
        for (int i = 2; i < 18; i++) begin
            tbl[i].st = 0;
            tbl[i].pw = 0;
            tbl[i].pin = '0;
            tbl[i].sin = '0;
            tbl[i].tk = ((i - 1) % 5 == 0);
            tbl[i].dn = (i == 16);
            tbl[i].bz = (i < 16);
            tbl[i].sc = 16'((i - 1) / 5);
        end

        model_reset();
        #2 rst = 0;
        #1;
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_step", {16'd0, step_cnt}, 32'd0);
        chk("rst_per", {8'd0, cur_period}, 32'd0);
        #10 rst = 1;

        // P=4, 3 steps: ticks 5/10/15 edges after start, done on the last.
        apply_table();

        // Running P=9, rewrite to 2 mid-period.
        clr(); period_wr = 1; period_in = 24'd9; start = 1;
        cycle();
        clr();
        repeat (4) cycle();
        period_wr = 1; period_in = 24'd2;
        cycle();
        clr();
        run_until_tick(20, n);
        chk("wr_first_gap", n, 5);
        run_until_tick(20, n);
        chk("wr_gap2", n, 3);
        run_until_tick(20, n);
        chk("wr_gap3", n, 3);
        halt();

        // Pause for 7 cycles mid-period.
        clr(); period_wr = 1; period_in = 24'd4; start = 1;
        cycle();
        clr();
        repeat (2) cycle();
        pause = 1;
        repeat (7) cycle();
        pause = 0;
        run_until_tick(20, n);
        chk("pause_gap", n, 3);
        halt();

        // Stop on the wrap edge: no tick, back to IDLE.
        clr(); period_wr = 1; period_in = 24'd3; start = 1;
        cycle();
        clr();
        repeat (3) cycle();
        stop = 1;
        cycle();
        chk("stopwrap_tick", {31'd0, tick}, 32'd0);
        chk("stopwrap_busy", {31'd0, busy}, 32'd0);
        clr();
        cycle();
        chk("stopwrap_tick2", {31'd0, tick}, 32'd0);

        // P=0 continuous: tick every cycle, step_cnt wraps.
        clr(); period_wr = 1; period_in = 24'd0; start = 1;
        cycle();
        clr();
        repeat (65535) cycle();
        chk("wrap_ffff", {16'd0, step_cnt}, 32'h0000_ffff);
        cycle();
        chk("wrap_zero", {16'd0, step_cnt}, 32'd0);
        chk("wrap_busy", {31'd0, busy}, 32'd1);
        halt();

        // Asynchronous reset mid-run, then the first scenario again.
        clr(); period_wr = 1; period_in = 24'd6; start = 1; steps_in = 16'd2;
        cycle();
        clr();
        repeat (9) cycle();
        #2 rst = 0;
        #1;
        model_reset();
        chk("mid_rst_tick", {31'd0, tick}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_step", {16'd0, step_cnt}, 32'd0);
        chk("mid_rst_per", {8'd0, cur_period}, 32'd0);
        @(negedge clk);
        rst = 1;
        apply_table();

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom % 8) == 0;
            stop = ($urandom % 40) == 0;
            pause = ($urandom % 10) == 0;
            period_wr = ($urandom % 15) == 0;
            period_in = 24'($urandom % 6);
            steps_in = 16'($urandom % 5);
            cycle();
        end
        clr();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
